// File: rtl/mul_csa_reduce_stage_pkg.sv
// mul_pkg: shared definitions for the multiplier reduction tree.
//   - default tree widths and the high-group offset
//   - default sideband tag width
//   - hold-tag encodings carried in the tag field and consumed by Ex
package mul_pkg;

  localparam int MUL_OUT_W        = 128;
  localparam int MUL_CSA_LO_W     = 98;
  localparam int MUL_CSA_HI_W     = 98;
  localparam int MUL_CSA_HI_SHIFT = 30;
  localparam int MUL_TAG_W        = 2;

  typedef enum logic [MUL_TAG_W-1:0] {
    HOLD_NONE = 2'd0,
    HOLD_EX   = 2'd1,
    HOLD_MEM  = 2'd2,
    HOLD_FULL = 2'd3
  } holdTag_e;

endpackage

// File: rtl/mul_csa_reduce_stage_csa_4to2.sv
// csa_4to2: combinational 4:2 carry-save compressor built from two chained
// 3:2 rows. Shared by every level of the multiplier tree.
//   a, b, c, d : W-bit operands
//   sum        : W-bit sum vector
//   carry      : W-bit carry vector, already weighted (bit 0 is always 0)
// Holds (sum + carry) mod 2^W == (a + b + c + d) mod 2^W; carries out of
// bit W-1 are discarded.
module csa_4to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] rowSum1;
  logic [W-1:0] rowMaj1;
  logic [W-1:0] rowCarry1;
  logic [W-1:0] rowMaj2;

  // first row compresses a, b, c
  assign rowSum1   = a ^ b ^ c;
  assign rowMaj1   = (a & b) | (a & c) | (b & c);
  assign rowCarry1 = rowMaj1 << 1;

  // second row folds d into the first row's result
  assign sum       = rowSum1 ^ rowCarry1 ^ d;
  assign rowMaj2   = (rowSum1 & rowCarry1) | (rowSum1 & d) | (rowCarry1 & d);
  assign carry     = rowMaj2 << 1;

endmodule

// File: rtl/mul_csa_reduce_stage.sv
// mul_csa_reduce_stage: registered 4:2 reduction stage with valid/ready flow
// control. Merges a low carry-save pair (at bit 0) and a high pair (at
// HI_SHIFT) into one OUT_W-wide sum/carry pair, with tag and sign sideband
// travelling in lockstep.
//
// Optional feature macro: MUL_CSA_SKID_EN
//   defined   : one-entry skid buffer, capacity 2, in_ready from a flop
//   undefined : capacity 1, in_ready combinational from out_ready
//
// Ports:
//   Clk                      clock, rising edge
//   Rst                      asynchronous reset, active low
//   flush                    synchronous kill of all valid state
//   in_valid / in_ready      input handshake
//   in_sum_lo / in_carry_lo  low carry-save pair (LO_W)
//   in_sum_hi / in_carry_hi  high carry-save pair (HI_W), offset HI_SHIFT
//   in_tag / in_sign         sideband
//   out_valid / out_ready    output handshake
//   out_sum / out_carry      merged pair (out_carry bit 0 always 0)
//   out_tag / out_sign       sideband aligned with out_sum/out_carry
module mul_csa_reduce_stage
  import mul_pkg::*;
#(
  parameter int OUT_W    = MUL_OUT_W,
  parameter int LO_W     = MUL_CSA_LO_W,
  parameter int HI_W     = MUL_CSA_HI_W,
  parameter int HI_SHIFT = MUL_CSA_HI_SHIFT,
  parameter int TAG_W    = MUL_TAG_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LO_W-1:0]  in_sum_lo,
  input  logic [LO_W-1:0]  in_carry_lo,
  input  logic [HI_W-1:0]  in_sum_hi,
  input  logic [HI_W-1:0]  in_carry_hi,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [OUT_W-1:0] out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sign
);

  if ((HI_SHIFT + HI_W > OUT_W) || (LO_W > OUT_W)) begin : gBadCfg
    $error("mul_csa_reduce_stage: operand groups do not fit in OUT_W");
  end

  logic [OUT_W-1:0] opA;
  logic [OUT_W-1:0] opB;
  logic [OUT_W-1:0] opC;
  logic [OUT_W-1:0] opD;
  logic [OUT_W-1:0] cmpSum;
  logic [OUT_W-1:0] cmpCarry;

  assign opA = OUT_W'(in_sum_lo);
  assign opB = OUT_W'(in_carry_lo);
  assign opC = OUT_W'(in_sum_hi) << HI_SHIFT;
  assign opD = OUT_W'(in_carry_hi) << HI_SHIFT;

  csa_4to2 #(
    .W(OUT_W)
  ) uCsa (
    .a    (opA),
    .b    (opB),
    .c    (opC),
    .d    (opD),
    .sum  (cmpSum),
    .carry(cmpCarry)
  );

  logic             outValidQ;
  logic [OUT_W-1:0] outSumQ;
  logic [OUT_W-1:0] outCarryQ;
  logic [TAG_W-1:0] outTagQ;
  logic             outSignQ;
  logic             accept;

  assign accept    = in_valid && in_ready;

  assign out_valid = outValidQ;
  assign out_sum   = outSumQ;
  assign out_carry = outCarryQ;
  assign out_tag   = outTagQ;
  assign out_sign  = outSignQ;

`ifdef MUL_CSA_SKID_EN

  logic             skidValidQ;
  logic [OUT_W-1:0] skidSumQ;
  logic [OUT_W-1:0] skidCarryQ;
  logic [TAG_W-1:0] skidTagQ;
  logic             skidSignQ;
  logic             outFree;

  // in_ready depends only on the skid flop, never on out_ready
  assign in_ready = !flush && !skidValidQ;
  assign outFree  = !outValidQ || out_ready;

  // output register: skid entry has priority since it is the older beat
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      outValidQ  <= 1'b0;
      skidValidQ <= 1'b0;
      outSumQ    <= '0;
      outCarryQ  <= '0;
      outTagQ    <= '0;
      outSignQ   <= 1'b0;
    end else if (flush) begin
      outValidQ  <= 1'b0;
      skidValidQ <= 1'b0;
    end else if (outFree) begin
      if (skidValidQ) begin
        outValidQ  <= 1'b1;
        skidValidQ <= 1'b0;
        outSumQ    <= skidSumQ;
        outCarryQ  <= skidCarryQ;
        outTagQ    <= skidTagQ;
        outSignQ   <= skidSignQ;
      end else if (accept) begin
        outValidQ  <= 1'b1;
        outSumQ    <= cmpSum;
        outCarryQ  <= cmpCarry;
        outTagQ    <= in_tag;
        outSignQ   <= in_sign;
      end else begin
        outValidQ  <= 1'b0;
      end
    end else if (accept) begin
      skidValidQ <= 1'b1;
    end
  end

  // skid payload is qualified by skidValidQ, so it needs no reset
  always_ff @(posedge Clk) begin
    if (accept && !outFree) begin
      skidSumQ   <= cmpSum;
      skidCarryQ <= cmpCarry;
      skidTagQ   <= in_tag;
      skidSignQ  <= in_sign;
    end
  end

`else

  // combinational path from out_ready: a beat may enter as the current one leaves
  assign in_ready = !flush && (!outValidQ || out_ready);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      outValidQ <= 1'b0;
      outSumQ   <= '0;
      outCarryQ <= '0;
      outTagQ   <= '0;
      outSignQ  <= 1'b0;
    end else if (flush) begin
      outValidQ <= 1'b0;
    end else if (accept) begin
      outValidQ <= 1'b1;
      outSumQ   <= cmpSum;
      outCarryQ <= cmpCarry;
      outTagQ   <= in_tag;
      outSignQ  <= in_sign;
    end else if (outValidQ && out_ready) begin
      outValidQ <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_mul_csa_reduce_stage.sv
module tb_mul_csa_reduce_stage;

`ifdef MUL_CSA_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [97:0]  in_sum_lo = '0;
  logic [97:0]  in_carry_lo = '0;
  logic [97:0]  in_sum_hi = '0;
  logic [97:0]  in_carry_hi = '0;
  logic [1:0]   in_tag = '0;
  logic         in_sign = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_sum;
  logic [127:0] out_carry;
  logic [1:0]   out_tag;
  logic         out_sign;

  int total = 0;
  int bad = 0;

  mul_csa_reduce_stage dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum_lo  (in_sum_lo),
    .in_carry_lo(in_carry_lo),
    .in_sum_hi  (in_sum_hi),
    .in_carry_hi(in_carry_hi),
    .in_tag     (in_tag),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .out_tag    (out_tag),
    .out_sign   (out_sign)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [97:0]  sl;
    logic [97:0]  cl;
    logic [97:0]  sh;
    logic [97:0]  ch;
    logic [1:0]   tag;
    logic         sign;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] tot;
    logic [1:0]   tag;
    logic         sign;
  } beat_t;

  vec_t  vecs[6];
  beat_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] refTotal(input logic [97:0] sl, input logic [97:0] cl,
                                            input logic [97:0] sh, input logic [97:0] ch);
    logic [127:0] a, b, c, d;
    a = {30'b0, sl};
    b = {30'b0, cl};
    c = {30'b0, sh} * (128'd1 << 30);
    d = {30'b0, ch} * (128'd1 << 30);
    return a + b + c + d;
  endfunction

  function automatic logic [97:0] rnd98();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 15) == 0) t = '1;
    return t[97:0];
  endfunction

  function automatic logic [127:0] outTotal();
    return out_sum + out_carry;
  endfunction

  task automatic drive(input logic [97:0] sl, input logic [97:0] cl, input logic [97:0] sh,
                       input logic [97:0] ch, input logic [1:0] tag, input logic sign);
    in_sum_lo = sl; in_carry_lo = cl; in_sum_hi = sh; in_carry_hi = ch;
    in_tag = tag; in_sign = sign;
  endtask

  initial begin
    logic [97:0] one97;
    logic [127:0] prevSum, prevCarry;
    logic [1:0] prevTag;
    logic prevSign, prevStall;
    int accepts, cycles;

    one97 = {1'b1, 97'b0};
    vecs[0] = '{98'd5, 98'd3, 98'd1, 98'd0, 2'd1, 1'b1, (128'd1 << 30) + 128'd8};
    vecs[1] = '{'1, '1, '1, '1, 2'd2, 1'b0, 128'h0000_0007_FFFF_FFFF_FFFF_FFFF_7FFF_FFFE};
    vecs[2] = '{98'd0, 98'd0, 98'd1, 98'd1, 2'd3, 1'b1, 128'h8000_0000};
    vecs[3] = '{one97, one97, 98'd0, 98'd0, 2'd0, 1'b0, 128'h0000_0004_0000_0000_0000_0000_0000_0000};
    vecs[4] = '{98'd0, 98'd0, one97, one97, 2'd1, 1'b0, 128'd0};
    vecs[5] = '{98'd7, 98'd0, 98'd0, 98'd2, 2'd2, 1'b1, 128'h8000_0007};

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_sign", out_sign, 0);
    @(negedge Clk); Rst = 1'b1; #1;
    chk("rst_in_ready", in_ready, 1);

    // table vectors, one beat at a time with out_ready=1
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      out_ready = 1'b1; in_valid = 1'b1;
      drive(vecs[i].sl, vecs[i].cl, vecs[i].sh, vecs[i].ch, vecs[i].tag, vecs[i].sign);
      #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(negedge Clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_total", i), outTotal(), vecs[i].exp);
      chk($sformatf("vec%0d_carry0", i), out_carry[0], 0);
      chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      chk($sformatf("vec%0d_sign", i), out_sign, vecs[i].sign);
    end
    @(negedge Clk); #1;
    chk("drain_valid", out_valid, 0);

    // back-pressure: A then B with out_ready low for 3 cycles
    @(negedge Clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(98'd11, 98'd0, 98'd0, 98'd0, 2'd1, 1'b0);
    #1 chk("bp_a_ready", in_ready, 1);
    @(negedge Clk);
    drive(98'd22, 98'd0, 98'd0, 98'd0, 2'd2, 1'b1);
    #1;
    chk("bp_a_valid", out_valid, 1);
    chk("bp_b_ready", in_ready, SKID ? 1 : 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (SKID) in_valid = 1'b0;
      #1;
      chk($sformatf("bp_hold%0d_total", k), outTotal(), 128'd11);
      chk($sformatf("bp_hold%0d_tag", k), out_tag, 2'd1);
      chk($sformatf("bp_hold%0d_ready", k), in_ready, 0);
    end
    @(negedge Clk);
    out_ready = 1'b1; #1;
    chk("bp_rel_total", outTotal(), 128'd11);
    chk("bp_rel_ready", in_ready, SKID ? 0 : 1);
    @(negedge Clk);
    in_valid = 1'b0; #1;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_total", outTotal(), 128'd22);
    chk("bp_b_tag", out_tag, 2'd2);
    chk("bp_b_ready", in_ready, 1);
    @(negedge Clk); #1;
    chk("bp_end_valid", out_valid, 0);

    // flush with a beat held and a new one offered
    @(negedge Clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(98'd33, 98'd0, 98'd0, 98'd0, 2'd3, 1'b0);
    @(negedge Clk);
    drive(98'd44, 98'd0, 98'd0, 98'd0, 2'd0, 1'b1);
    flush = 1'b1; #1;
    chk("fl_ready", in_ready, 0);
    chk("fl_valid_before", out_valid, 1);
    @(negedge Clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("fl_valid_after", out_valid, 0);
    @(negedge Clk); #1;
    chk("fl_no_ghost", out_valid, 0);

    // asynchronous reset while stalled
    @(negedge Clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(98'd55, 98'd9, 98'd3, 98'd0, 2'd3, 1'b1);
    @(negedge Clk);
    in_valid = 1'b0; #1;
    chk("ar_valid_before", out_valid, 1);
    #2 Rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_sum", out_sum, 0);
    chk("ar_carry", out_carry, 0);
    chk("ar_tag", out_tag, 0);
    chk("ar_sign", out_sign, 0);
    @(negedge Clk);
    Rst = 1'b1; #1;
    chk("ar_ready_after", in_ready, 1);
    chk("ar_valid_after", out_valid, 0);

    // random soak against a queue model
    q.delete();
    accepts = 0;
    cycles = 0;
    prevStall = 1'b0;
    prevSum = '0; prevCarry = '0; prevTag = '0; prevSign = 1'b0;
    while (accepts < 10000 && cycles < 50000) begin
      logic expReady, acc, xfer;
      @(negedge Clk);
      cycles++;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      drive(rnd98(), rnd98(), rnd98(), rnd98(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      #1;
      expReady = !flush && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_ready", in_ready, expReady);
      if (q.size() > 0) begin
        chk("rnd_total", outTotal(), q[0].tot);
        chk("rnd_tag", out_tag, q[0].tag);
        chk("rnd_sign", out_sign, q[0].sign);
        chk("rnd_carry0", out_carry[0], 0);
      end
      if (prevStall) begin
        chk("rnd_hold_sum", out_sum, prevSum);
        chk("rnd_hold_carry", out_carry, prevCarry);
        chk("rnd_hold_tag", out_tag, prevTag);
        chk("rnd_hold_sign", out_sign, prevSign);
      end
      prevStall = (q.size() > 0) && !out_ready && !flush;
      prevSum = out_sum; prevCarry = out_carry; prevTag = out_tag; prevSign = out_sign;
      acc  = in_valid && expReady;
      xfer = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (xfer) void'(q.pop_front());
        if (acc) begin
          q.push_back('{refTotal(in_sum_lo, in_carry_lo, in_sum_hi, in_carry_hi), in_tag, in_sign});
          accepts++;
        end
      end
    end
    if (accepts < 10000) begin
      total++;
      bad++;
      $display("FAIL soak_budget accepted=%0d required=10000", accepts);
    end

    @(negedge Clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_csa_reduce_stage.md
# mul_csa_reduce_stage

Parametrised, registered 4:2 carry-save reduction stage for the Balotelli ALU multiplier tree, with valid/ready flow control. It merges two offset carry-save pairs (low and high partial-product groups) into one OUT_W-wide sum/carry pair. It carries the multiplier sideband (op tag, sign-correction bit) in lockstep with the data. Unlike the fixed fourth-level stage, it supports back-pressure, flush, configurable widths and offsets, and an optional skid buffer. It can be instantiated at any tree level.

## Interface
Parameters:
- OUT_W, 128: width of the merged sum/carry outputs.
- LO_W, 98: width of the low pair; placed at bit 0, zero-extended to OUT_W.
- HI_W, 98: width of the high pair.
- HI_SHIFT, 30: left offset of the high pair inside OUT_W. Legal only if HI_SHIFT+HI_W ≤ OUT_W and LO_W ≤ OUT_W; an elaboration error fires otherwise.
- TAG_W, 2: width of the sideband tag (hold-flag field).

Ports:
- Clk, in, 1: clock; all state updates on rising edge.
- Rst, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous pipeline kill.
- in_valid, in, 1: input pair valid.
- in_ready, out, 1: stage accepts input this cycle.
- in_sum_lo / in_carry_lo, in, LO_W: low carry-save pair.
- in_sum_hi / in_carry_hi, in, HI_W: high carry-save pair.
- in_tag, in, TAG_W: sideband tag.
- in_sign, in, 1: multiplier-MSB sign-correction bit.
- out_valid, out, 1: output valid.
- out_ready, in, 1: downstream accepts.
- out_sum / out_carry, out, OUT_W: merged pair. out_carry is pre-weighted, bit 0 always 0.
- out_tag, out, TAG_W: tag aligned with the data.
- out_sign, out, 1: sign bit aligned with the data.

## Operation
- Operands a, b, c, d are, in order: zext(in_sum_lo), zext(in_carry_lo), zext(in_sum_hi)<<HI_SHIFT, zext(in_carry_hi)<<HI_SHIFT, each truncated to OUT_W.
- Invariant: (out_sum + out_carry) mod 2^OUT_W = (a+b+c+d) mod 2^OUT_W.
- Overflow past OUT_W is discarded silently.
- Reduction is one combinational 4:2 compressor, built as two chained 3:2 rows, in front of the output register.
- An accept occurs when in_valid && in_ready. On accept, the output register loads the compressed result, in_tag and in_sign, and out_valid is set.
- A transfer occurs when out_valid && out_ready. On transfer with no accept, out_valid clears.
- Accept and transfer in the same cycle: the register reloads and out_valid stays 1.
- With out_valid=1 and out_ready=0, the outputs hold stable (no change to any out_* bit).
- flush=1: all valid bits clear at the next edge and in_ready=0 during that cycle. An input offered during a flush cycle is dropped; data registers may keep stale values.
- Reset (at any time, including mid-transfer): out_valid=0, out_sum=0, out_carry=0, out_tag=0, out_sign=0, skid entry empty. in_ready is 1 after Rst deasserts, unless flush is high.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Without the skid buffer: in_ready = !flush && (!out_valid || out_ready). This is a combinational path from out_ready.
- With the skid buffer: in_ready = !flush && skid_empty, driven from a flop with no out_ready dependency.
  - When out_valid=1, out_ready=0 and an accept occurs, the new beat goes to the skid entry.
  - Next cycle in_ready=0.
  - On the following transfer, the skid entry moves to the output register and in_ready returns to 1.
- Nothing is dropped or duplicated under any valid/ready pattern, flush excepted.

## Configuration
- MUL_CSA_SKID_EN defined: a one-entry skid buffer is added (data, tag, sign, valid), giving a total capacity of 2 beats and a registered in_ready.
- Not defined: capacity is 1 beat and in_ready is combinational as above. The skid registers are absent.

## Structure
- Shared package mul_pkg holds:
  - default widths (MUL_OUT_W=128, MUL_CSA_LO_W, MUL_CSA_HI_W, MUL_CSA_HI_SHIFT);
  - the TAG_W default of 2;
  - the hold-tag encodings used by Ex.
- Sub-module csa_4to2: purely combinational, parameter W, inputs a/b/c/d, outputs sum/carry (carry already shifted by 1). It is reused by the other tree levels.
- The top level contains only the operand alignment, the handshake, the output register and the optional skid buffer.

## Test plan
- Basic merge, defaults: sum_lo=5, carry_lo=3, sum_hi=1, carry_hi=0, out_ready=1 -> one cycle later out_valid=1, out_sum+out_carry=2^30+8, tag and sign echoed.
- Back-pressure: beats A, B offered back to back with out_ready=0 for 3 cycles.
  - Without SKID: A holds stable on the outputs and in_ready=0.
  - With SKID: B is accepted into the skid entry, then in_ready=0.
  - Releasing out_ready delivers A then B, in order, with no gap.
- Wrap: all inputs all-ones with LO_W=HI_W=98, HI_SHIFT=30 -> out_sum+out_carry equals the true sum mod 2^128, and carry bit 0 is 0.
- Flush: flush asserted while out_valid=1 and a new in_valid is offered -> next cycle out_valid=0 and the offered beat never appears at the output.
- Async reset mid-stall: Rst driven low between edges while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, in_ready=1.
- Random soak: 10k random beats with random in_valid/out_ready/flush, in both macro builds -> scoreboard matches the invariant and order for every non-flushed beat.
